// File: rtl/conv33_pkg.sv
// Shared types and constants for the conv33_stream 3x3 convolution engine.
package conv33_pkg;

  typedef enum logic [1:0] {
    MODE_SHARPEN = 2'd0,
    MODE_GAUSS   = 2'd1,
    MODE_EDGE    = 2'd2,
    MODE_IDENT   = 2'd3
  } mode_e;

  typedef logic signed [4:0] coef_t;

  // Row-major, index 0 is the top-left (oldest row, oldest column) tap.
  localparam coef_t K_SHARPEN [9] = '{5'sd0, -5'sd1, 5'sd0, -5'sd1, 5'sd5, -5'sd1, 5'sd0, -5'sd1, 5'sd0};
  localparam coef_t K_GAUSS   [9] = '{5'sd1, 5'sd2, 5'sd1, 5'sd2, 5'sd4, 5'sd2, 5'sd1, 5'sd2, 5'sd1};
  localparam coef_t K_EDGE    [9] = '{-5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd8, -5'sd1, -5'sd1, -5'sd1, -5'sd1};
  localparam coef_t K_IDENT   [9] = '{5'sd0, 5'sd0, 5'sd0, 5'sd0, 5'sd1, 5'sd0, 5'sd0, 5'sd0, 5'sd0};

  localparam int unsigned GAUSS_SHIFT = 32'd4;
  localparam int          GAUSS_RND   = 32'sd8;

  function automatic coef_t kernel_coef(input mode_e m, input int idx);
    case (m)
      MODE_SHARPEN: kernel_coef = K_SHARPEN[idx];
      MODE_GAUSS:   kernel_coef = K_GAUSS[idx];
      MODE_EDGE:    kernel_coef = K_EDGE[idx];
      MODE_IDENT:   kernel_coef = K_IDENT[idx];
      default:      kernel_coef = K_IDENT[idx];
    endcase
  endfunction

endpackage

// File: rtl/conv33_line_buffer.sv
// Single-clock line RAM addressed by column; the read port shows the old word
// during a write cycle, so one beat both fetches the previous row and stores the new one.
module conv33_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Contents are never reset; every word is rewritten before it is used in a frame.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv33_stream.sv
// Streaming 3x3 convolution: raster pixels in, interior results out after a 2-stage pipeline.
// Build option: CONV33_ABS_EDGE_EN makes edge mode emit |sum| before the upper clamp.
module conv33_stream
  import conv33_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int NUM_CH      = 1,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int ACCW        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] in_data,
  input  logic [1:0]                    mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic [NUM_CH*PIXEL_WIDTH-1:0] out_data
);

  localparam int DW = NUM_CH * PIXEL_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic signed [ACCW-1:0] PIX_MAX  = ACCW'((32'sd1 <<< PIXEL_WIDTH) - 32'sd1);
  localparam logic signed [ACCW-1:0] ACC_ZERO = {ACCW{1'b0}};

  if (ACCW < PIXEL_WIDTH + 5) begin : g_bad_accw
    $error("conv33_stream: ACCW must be >= PIXEL_WIDTH+5");
  end
  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_dims
    $error("conv33_stream: IMG_W and IMG_H must be >= 3");
  end

  logic          active_q, active_d;
  logic [CW-1:0] col_q, col_d, cur_col_s;
  logic [RW-1:0] row_q, row_d, cur_row_s;
  mode_e         mode_q, mode_d, s1_mode_q;
  logic          take_s;
  logic [DW-1:0] lb0_rd_s, lb1_rd_s, res_s;
  logic [DW-1:0] win_q [3][3];
  logic          s1_valid_q, s1_sof_q, s1_eof_q;
  logic signed [ACCW-1:0] acc_s;

  assign in_ready  = !out_valid || out_ready;
  // Beats before the first sof are accepted but ignored.
  assign take_s    = in_valid && in_ready && (in_sof || active_q);
  assign cur_col_s = in_sof ? {CW{1'b0}} : col_q;
  assign cur_row_s = in_sof ? {RW{1'b0}} : row_q;

  // lb0 holds row r-1, lb1 holds row r-2; lb0's old word cascades into lb1.
  conv33_line_buffer #(.WIDTH(DW), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .en_i(take_s), .addr_i(cur_col_s), .wdata_i(in_data), .rdata_o(lb0_rd_s)
  );
  conv33_line_buffer #(.WIDTH(DW), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .en_i(take_s), .addr_i(cur_col_s), .wdata_i(lb0_rd_s), .rdata_o(lb1_rd_s)
  );

  always_comb begin
    active_d = active_q;
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    if (take_s) begin
      active_d = 1'b1;
      mode_d   = in_sof ? mode_e'(mode) : mode_q;
      if (cur_col_s == CW'(IMG_W - 1)) begin
        col_d = {CW{1'b0}};
        if (cur_row_s == RW'(IMG_H - 1)) begin
          row_d    = {RW{1'b0}};
          active_d = 1'b0;
        end else begin
          row_d = cur_row_s + RW'(1);
        end
      end else begin
        col_d = cur_col_s + CW'(1);
        row_d = cur_row_s;
      end
    end else begin
      active_d = active_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      col_q    <= {CW{1'b0}};
      row_q    <= {RW{1'b0}};
      mode_q   <= MODE_SHARPEN;
    end else begin
      active_q <= active_d;
      col_q    <= col_d;
      row_q    <= row_d;
      mode_q   <= mode_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_mode_q  <= MODE_SHARPEN;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= {DW{1'b0}};
        end
      end
    end else if (in_ready) begin
      s1_valid_q <= take_s && (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
      if (take_s) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd_s;
        win_q[1][2] <= lb0_rd_s;
        win_q[2][2] <= in_data;
        s1_sof_q    <= (cur_row_s == RW'(2)) && (cur_col_s == CW'(2));
        s1_eof_q    <= (cur_row_s == RW'(IMG_H - 1)) && (cur_col_s == CW'(IMG_W - 1));
        s1_mode_q   <= mode_d;
      end
    end
  end

  function automatic logic [PIXEL_WIDTH-1:0] sat_px(input logic signed [ACCW-1:0] sum, input mode_e m);
    logic signed [ACCW-1:0] v;
    if (m == MODE_GAUSS) begin
      v = (sum + ACCW'(GAUSS_RND)) >>> GAUSS_SHIFT;
`ifdef CONV33_ABS_EDGE_EN
    end else if (m == MODE_EDGE && sum < ACC_ZERO) begin
      v = -sum;
`endif
    end else begin
      v = sum;
    end
    if (v < ACC_ZERO) begin
      sat_px = {PIXEL_WIDTH{1'b0}};
    end else if (v > PIX_MAX) begin
      sat_px = {PIXEL_WIDTH{1'b1}};
    end else begin
      sat_px = v[PIXEL_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    res_s = {DW{1'b0}};
    acc_s = ACC_ZERO;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      acc_s = ACC_ZERO;
      for (int i = 0; i < 9; i++) begin
        acc_s = acc_s + $signed(ACCW'(win_q[i / 3][i % 3][ch*PIXEL_WIDTH +: PIXEL_WIDTH]))
                      * ACCW'(kernel_coef(s1_mode_q, i));
      end
      res_s[ch*PIXEL_WIDTH +: PIXEL_WIDTH] = sat_px(acc_s, s1_mode_q);
    end
  end

  // Output register only advances when downstream can take it, so it holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= {DW{1'b0}};
    end else if (in_ready) begin
      out_valid <= s1_valid_q;
      out_sof   <= s1_valid_q && s1_sof_q;
      out_eof   <= s1_valid_q && s1_eof_q;
      if (s1_valid_q) begin
        out_data <= res_s;
      end
    end
  end

endmodule

// File: tb/tb_conv33_stream.sv
// Scoreboard bench for conv33_stream on a 5x4 single-channel 8-bit image.
module tb_conv33_stream;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_sof, out_valid, out_ready, out_sof, out_eof;
  logic [7:0] in_data, out_data;
  logic [1:0] mode;

  typedef struct packed {logic [7:0] d; logic sof; logic eof;} exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int n_out  = 0;
  bit rdy_toggle = 1'b0;
  int img [H][W];

  localparam int KS [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  localparam int KG [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int KE [9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
  localparam int KI [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  conv33_stream #(.PIXEL_WIDTH(8), .NUM_CH(1), .IMG_W(W), .IMG_H(H), .ACCW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int kcoef(int m, int i);
    case (m)
      0: return KS[i];
      1: return KG[i];
      2: return KE[i];
      default: return KI[i];
    endcase
  endfunction

  // Reference result for the input beat at (r,c): window centred at (r-1,c-1).
  function automatic int model_px(int r, int c, int m);
    int s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += img[r-2+dr][c-2+dc] * kcoef(m, dr*3 + dc);
    if (m == 1) s = (s + 8) >>> 4;
`ifdef CONV33_ABS_EDGE_EN
    if (m == 2 && s < 0) s = -s;
`endif
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
    return s;
  endfunction

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(0, 255));
  endtask

  // Starts and ends just after a rising edge.
  task automatic send_beat(input logic [7:0] d, input bit sof, input int m, input bit gap);
    bit acc = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    mode     = 2'(m);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check_eq("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send_frame_n(input int m, input int m_late, input bit gaps, input int nbeats);
    int k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k < nbeats) begin
          if (r >= 2 && c >= 2) begin
            sb.push_back('{d: 8'(model_px(r, c, m)), sof: (r == 2 && c == 2), eof: (r == H-1 && c == W-1)});
            n_push++;
          end
          send_beat(8'(img[r][c]), (r == 0 && c == 0), (k == 0) ? m : m_late, gaps);
          k++;
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 200 && sb.size() != 0; n++) begin @(posedge clk); #1; end
    repeat (4) begin @(posedge clk); #1; end
    check_eq(tag, sb.size(), 0);
    check_eq("out_count", n_out, n_push);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_toggle ? ~out_ready : 1'b1;
    end
  end

  // Every cycle with out_valid is compared with the head entry, so held data is checked too.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        check_eq("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          check_eq("out_data", out_data, sb[0].d);
          check_eq("out_sof", out_sof, sb[0].sof);
          check_eq("out_eof", out_eof, sb[0].eof);
          if (out_ready) begin
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sof", out_sof, 0);
    check_eq("rst_out_eof", out_eof, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    fill_const(100);
    for (int m = 0; m < 4; m++) begin
      send_frame_n(m, m, 1'b0, W*H);
      drain("drain_const");
    end

    fill_const(0); img[1][1] = 255;
    send_frame_n(2, 2, 1'b0, W*H);
    drain("drain_edge_imp");

    fill_const(0); img[1][2] = 16;
    send_frame_n(1, 1, 1'b0, W*H);
    drain("drain_gauss_imp");

    fill_rand();
    rdy_toggle = 1'b1;
    send_frame_n(0, 0, 1'b1, W*H);
    send_frame_n(1, 1, 1'b1, W*H);
    drain("drain_stall");
    rdy_toggle = 1'b0;

    fill_rand();
    send_frame_n(0, 2, 1'b0, W*H);
    send_frame_n(2, 2, 1'b0, W*H);
    drain("drain_mode_chg");

    fill_rand();
    send_frame_n(1, 1, 1'b0, 6);
    send_frame_n(0, 0, 1'b0, W*H);
    drain("drain_restart");

    fill_rand();
    send_frame_n(3, 3, 1'b0, 13);
    @(posedge clk); #2;
    check_eq("pre_rst_valid", out_valid, 1);
    if (sb.size() != 0) check_eq("pre_rst_data", out_data, sb[0].d);
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_in_ready", in_ready, 1);
    fl = sb.size();
    sb.delete();
    n_push -= fl;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) send_beat(8'd77, 1'b0, 0, 1'b0);
    in_valid = 1'b0;
    fill_rand();
    send_frame_n(1, 1, 1'b0, W*H);
    drain("drain_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv33_stream.md
Name: conv33_stream

Overview:
- Streaming 3x3 image convolution engine; successor to the fixed single-window conv33 core.
- Accepts raster-order pixels over a valid/ready stream and holds two internal line buffers, so the upstream sends one pixel per beat instead of three rows.
- Processes NUM_CH channels in parallel with one shared kernel selected per frame.
- Emits the "valid" (interior-only) convolution result, saturated to unsigned PIXEL_WIDTH, with frame markers.

Parameters:
- PIXEL_WIDTH, 8, bits per channel sample (unsigned).
- NUM_CH, 1, channels per pixel, packed with ch0 in the LSBs.
- IMG_W, 640, pixels per line; must be >= 3.
- IMG_H, 480, lines per frame; must be >= 3.
- ACCW, 16, signed accumulator width; must be >= PIXEL_WIDTH+5. An elaboration error is raised otherwise.

Ports:
- clk  in  1  single clock, one pixel per accepted beat.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_sof  in  1  marks pixel (0,0) of a frame; qualified by in_valid&in_ready.
- in_data  in  NUM_CH*PIXEL_WIDTH  input pixel.
- mode  in  2  0=sharpen, 1=gaussian, 2=edge (Laplacian), 3=identity; sampled at accepted in_sof.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_sof  out  1  first output pixel of frame.
- out_eof  out  1  last output pixel of frame.
- out_data  out  NUM_CH*PIXEL_WIDTH  filtered pixel.

Behaviour:
- Reset values: all outputs 0 except in_ready, which is 1. Counters, window, mode register and pipeline valids are cleared. Line buffer contents are don't-care.
- Reset asserted mid-frame: everything in flight is discarded. After release, the block waits for in_sof; pixels without a prior sof are accepted and dropped.
- Column/row counters advance on each accepted beat. Column wraps at IMG_W-1 and increments row. Row wraps at IMG_H-1 back to the idle-for-sof state.
- Accepted in_sof forces position (0,0), regardless of the current count (frame restart). Pipeline contents already in flight still drain.
- Line buffers:
  - Two IMG_W-deep RAMs, NUM_CH*PIXEL_WIDTH wide, addressed by column.
  - Reads and writes occur on the same accepted beat, read-before-write.
  - The window shifts left one column per accepted beat.
- Output generation:
  - An output is produced for the accepted input at (r,c) with r>=2 and c>=2. Its window is centred at (r-1,c-1).
  - Output count per frame is (IMG_W-2)*(IMG_H-2).
- Kernels (signed coefficients, row-major):
  - Sharpen: 0,-1,0 / -1,5,-1 / 0,-1,0.
  - Gaussian: 1,2,1 / 2,4,2 / 1,2,1, then (sum+8)>>>4.
  - Edge: -1,-1,-1 / -1,8,-1 / -1,-1,-1.
  - Identity: centre only.
- Arithmetic: samples are zero-extended to ACCW. The sum is computed in ACCW signed, then clamped: <0 gives 0, >2^PIXEL_WIDTH-1 gives max. Channels are independent.
- Pipeline: stage 1 registers the window and computes the sum; stage 2 applies shift/saturate into the output register.
  - Latency is 2 cycles from accepting the completing input beat to out_valid, with no stalls.
- Flow control:
  - in_ready = !s2_valid | out_ready. A stall freezes both stages and the line buffers.
  - Full throughput is one pixel per cycle.
  - out_data, out_sof and out_eof are held stable while out_valid & !out_ready.
- out_sof is asserted on the output for input (2,2). out_eof is asserted on the output for input (IMG_H-1,IMG_W-1).
- mode changes outside an accepted sof have no effect until the next frame.

Optional Feature:
- CONV33_ABS_EDGE_EN.
- Defined: in mode 2 the signed sum is replaced by its absolute value before the upper clamp, so negative edges appear bright.
- Undefined: negative results clamp to 0 like all other modes.

Decomposition:
- Package conv33_pkg:
  - mode enum (MODE_SHARPEN, MODE_GAUSS, MODE_EDGE, MODE_IDENT).
  - 3x3 coefficient constant arrays per mode.
  - Gaussian shift (4) and rounding constant (8).
- One sub-module: conv33_line_buffer, a parametrised single-clock RAM with enable, read-before-write, width NUM_CH*PIXEL_WIDTH and depth IMG_W. It is instantiated twice.

Test Plan (IMG_W=5, IMG_H=4, NUM_CH=1, PIXEL_WIDTH=8 unless stated):
- Constant 100 frame, modes 0/1/3 -> 6 outputs, all 100. Mode 2 -> all 0. out_sof on the 1st output, out_eof on the 6th.
- Zeros with 255 at (1,1), mode 2 -> output(1,1)=255 (8*255 clamped), outputs(1,2),(2,1),(2,2)=0. With CONV33_ABS_EDGE_EN -> those three are 255.
- Gaussian with impulse 16 at (1,2) -> outputs (1,1)=2, (1,2)=4, (2,1)=1, (2,2)=2, (1,3)=2, (2,3)=1.
- out_ready toggling 1010... and random in_valid gaps -> identical 6 outputs in order, no duplicates, data stable under stall.
- mode changed 0->2 mid-frame -> frame stays sharpen. Next sof uses edge. A new sof at the 7th beat restarts counting with no stale output.
- rst_n pulse mid-frame -> out_valid=0 asynchronously, in_ready=1. The next full frame is correct.
